// File: rtl/banked_data_memory.sv
// Byte-banked data memory with RISC-V style load/store sizes.
// Word-crossing accesses take a second beat when ALLOW_MISALIGNED is set, otherwise they fault.
module banked_data_memory #(
    parameter int ADDR_BITS        = 7,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);
    localparam int WI    = ADDR_BITS - 2;
    localparam int DEPTH = 1 << WI;

    typedef enum logic {IDLE, SECOND} state_t;
    state_t state;

    logic [7:0] mem [4][DEPTH];

    logic [1:0]    off;
    logic [WI-1:0] widx;
    logic [2:0]    nbytes;
    logic          misaligned;
    logic          crossing;
    logic          fault_req;
    logic          accept;
    logic [1:0]    lane [4];
    logic [3:0]    first_mask;
    logic [3:0]    second_mask;
    logic [31:0]   wlanes;
    logic [31:0]   rd_cur;
    logic [31:0]   rd_sec;
    logic [31:0]   hold32;
    logic [31:0]   merged;

    logic          sec_write;
    logic [1:0]    sec_off;
    logic [2:0]    sec_size;
    logic [3:0]    sec_mask;
    logic [WI-1:0] sec_word;
    logic [31:0]   sec_lanes;
    logic [23:0]   hold;

    logic [3:0]    wr_mask;
    logic [WI-1:0] wr_word;
    logic [31:0]   wr_lanes;

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_BITS];

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] size);
        case (size)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'h000000, raw[7:0]};
            3'b101:  return {16'h0000, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Data is kept "access-ordered" (byte i = address+i) on the read side and
    // "bank-ordered" (lane k = bank k) on the write side; lane[] maps between them.
    always_comb begin
        off  = req_addr[1:0];
        widx = req_addr[ADDR_BITS-1:2];
        case (req_size)
            3'b000, 3'b100: nbytes = 3'd1;
            3'b001, 3'b101: nbytes = 3'd2;
            3'b010:         nbytes = 3'd4;
            default:        nbytes = 3'd0;
        endcase
        misaligned = ((nbytes == 3'd2) && off[0]) || ((nbytes == 3'd4) && (off != 2'd0));
        crossing   = ({1'b0, off} + nbytes) > 3'd4;
        fault_req  = (nbytes == 3'd0) || (misaligned && !ALLOW_MISALIGNED);

        lane        = '{default: 2'd0};
        first_mask  = '0;
        second_mask = '0;
        wlanes      = '0;
        rd_cur      = '0;
        rd_sec      = '0;
        for (int k = 0; k < 4; k++) begin
            lane[k]          = 2'(k) - off;
            first_mask[k]    = (2'(k) >= off) && ({1'b0, lane[k]} < nbytes);
            second_mask[k]   = (2'(k) < off) && ({1'b0, lane[k]} < nbytes);
            wlanes[8*k +: 8] = req_wdata[{lane[k], 3'b000} +: 8];
            rd_cur[8*k +: 8] = mem[2'(k) + off][widx];
            rd_sec[8*k +: 8] = mem[2'(k) + sec_off][sec_word];
        end

        hold32 = {8'h00, hold};
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            if (({1'b0, sec_off} + 3'(i)) < 3'd4)
                merged[8*i +: 8] = hold32[8*i +: 8];
            else
                merged[8*i +: 8] = rd_sec[8*i +: 8];
        end
    end

    always_comb begin
        wr_mask  = '0;
        wr_word  = widx;
        wr_lanes = wlanes;
        if (!rst) begin
            if (state == SECOND) begin
                if (sec_write)
                    wr_mask = sec_mask;
                wr_word  = sec_word;
                wr_lanes = sec_lanes;
            end else if (accept && req_write && !fault_req) begin
                wr_mask = first_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_mask[k])
                mem[k][wr_word] <= wr_lanes[8*k +: 8];
        end
    end

    // First-beat load bytes wait in hold until the neighbouring word is read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
            hold      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (fault_req) begin
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                        end else if (crossing) begin
                            state     <= SECOND;
                            sec_write <= req_write;
                            sec_off   <= off;
                            sec_size  <= req_size;
                            sec_mask  <= second_mask;
                            sec_word  <= widx + WI'(1);
                            sec_lanes <= wlanes;
                            hold      <= rd_cur[23:0];
                        end else begin
                            rsp_valid <= 1'b1;
                            if (!req_write)
                                rsp_rdata <= extend(rd_cur, req_size);
                        end
                    end
                end
                SECOND: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    if (!sec_write)
                        rsp_rdata <= extend(merged, sec_size);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
